// File: rtl/bill_cart_accumulator.sv
// Sequential shopping cart: per-product saturating counts, frozen on checkout until billing acks.
// Optional one-step undo of the last successful scan is built when CART_UNDO_EN is defined.
module bill_cart_accumulator #(
    parameter int QTY_W   = 4,
    parameter int MAX_QTY = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             scan_valid,
    input  logic [2:0]       scan_item,
    input  logic             scan_remove,
    output logic             scan_ready,
    input  logic             checkout,
    input  logic             cart_ack,
    input  logic             undo,
    output logic [QTY_W-1:0] q1,
    output logic [QTY_W-1:0] q2,
    output logic [QTY_W-1:0] q3,
    output logic [QTY_W-1:0] q4,
    output logic [QTY_W-1:0] q5,
    output logic [6:0]       item_total,
    output logic             cart_valid,
    output logic             cart_empty,
    output logic             scan_err
);
    localparam int N_ITEMS = 5;

    typedef enum logic [1:0] {IDLE, SHOP, HOLD} state_t;

    state_t           state_q, state_d;
    logic [QTY_W-1:0] qty_q [N_ITEMS];
    logic [QTY_W-1:0] qty_d [N_ITEMS];
    logic [6:0]       total_q, total_d;
    logic             valid_q, valid_d;
    logic             empty_q, empty_d;
    logic             err_q, err_d;

    logic             op_en;
    logic             op_rem;
    logic [2:0]       op_item;
    logic             any_d;

`ifdef CART_UNDO_EN
    logic             op_ok;
    logic             hist_vld_q, hist_vld_d;
    logic [2:0]       hist_item_q, hist_item_d;
    logic             hist_rem_q, hist_rem_d;
`else
    logic             unused_undo;
    assign unused_undo = undo;
`endif

    always_comb begin
        state_d = state_q;
        qty_d   = qty_q;
        valid_d = valid_q;
        err_d   = 1'b0;
        op_en   = 1'b0;
        op_rem  = 1'b0;
        op_item = 3'd0;
        any_d   = 1'b0;
        total_d = '0;
`ifdef CART_UNDO_EN
        op_ok       = 1'b0;
        hist_vld_d  = hist_vld_q;
        hist_item_d = hist_item_q;
        hist_rem_d  = hist_rem_q;
`endif
        if (state_q == HOLD) begin
            if (cart_ack) begin
                for (int i = 0; i < N_ITEMS; i++) qty_d[i] = '0;
                valid_d = 1'b0;
                state_d = IDLE;
`ifdef CART_UNDO_EN
                hist_vld_d = 1'b0;
`endif
            end
        end else begin
            if (scan_valid) begin
                op_en   = 1'b1;
                op_item = scan_item;
                op_rem  = scan_remove;
            end
`ifdef CART_UNDO_EN
            else if (undo) begin
                // Replaying the inverse cannot saturate: the history's own step just moved away from that bound.
                if (hist_vld_q) begin
                    op_en   = 1'b1;
                    op_item = hist_item_q;
                    op_rem  = ~hist_rem_q;
                end else begin
                    err_d = 1'b1;
                end
                hist_vld_d = 1'b0;
            end
`endif
            if (op_en) begin
                if (op_item >= 3'(N_ITEMS)) err_d = 1'b1;
                for (int i = 0; i < N_ITEMS; i++) begin
                    if (op_item == 3'(i)) begin
                        if (op_rem) begin
                            if (qty_q[i] == '0) err_d = 1'b1;
                            else begin
                                qty_d[i] = qty_q[i] - QTY_W'(1);
`ifdef CART_UNDO_EN
                                op_ok = 1'b1;
`endif
                            end
                        end else begin
                            if (qty_q[i] == QTY_W'(MAX_QTY)) err_d = 1'b1;
                            else begin
                                qty_d[i] = qty_q[i] + QTY_W'(1);
`ifdef CART_UNDO_EN
                                op_ok = 1'b1;
`endif
                            end
                        end
                    end
                end
            end
`ifdef CART_UNDO_EN
            if (op_ok && scan_valid) begin
                hist_vld_d  = 1'b1;
                hist_item_d = scan_item;
                hist_rem_d  = scan_remove;
            end
`endif
            for (int i = 0; i < N_ITEMS; i++) any_d = any_d | (qty_d[i] != '0);
            state_d = any_d ? SHOP : IDLE;
            if (checkout) begin
                state_d = HOLD;
                valid_d = 1'b1;
`ifdef CART_UNDO_EN
                hist_vld_d = 1'b0;
`endif
            end
        end
        any_d = 1'b0;
        for (int i = 0; i < N_ITEMS; i++) begin
            total_d = total_d + 7'(qty_d[i]);
            any_d   = any_d | (qty_d[i] != '0);
        end
        empty_d = ~any_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            for (int i = 0; i < N_ITEMS; i++) qty_q[i] <= '0;
            total_q <= '0;
            valid_q <= 1'b0;
            empty_q <= 1'b1;
            err_q   <= 1'b0;
`ifdef CART_UNDO_EN
            hist_vld_q  <= 1'b0;
            hist_item_q <= 3'd0;
            hist_rem_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            qty_q   <= qty_d;
            total_q <= total_d;
            valid_q <= valid_d;
            empty_q <= empty_d;
            err_q   <= err_d;
`ifdef CART_UNDO_EN
            hist_vld_q  <= hist_vld_d;
            hist_item_q <= hist_item_d;
            hist_rem_q  <= hist_rem_d;
`endif
        end
    end

    assign scan_ready = (state_q != HOLD);
    assign q1         = qty_q[0];
    assign q2         = qty_q[1];
    assign q3         = qty_q[2];
    assign q4         = qty_q[3];
    assign q5         = qty_q[4];
    assign item_total = total_q;
    assign cart_valid = valid_q;
    assign cart_empty = empty_q;
    assign scan_err   = err_q;

endmodule

// File: tb/tb_bill_cart_accumulator.sv
// Self-checking bench for bill_cart_accumulator: directed test-plan steps then random traffic vs. a cart model.
module tb_bill_cart_accumulator;
    localparam int MAXQ = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scan_valid = 1'b0;
    logic [2:0] scan_item = 3'd0;
    logic       scan_remove = 1'b0;
    logic       checkout = 1'b0;
    logic       cart_ack = 1'b0;
    logic       undo = 1'b0;
    logic       scan_ready;
    logic [3:0] q1, q2, q3, q4, q5;
    logic [6:0] item_total;
    logic       cart_valid, cart_empty, scan_err;

    int tests = 0;
    int fails = 0;

    int m_q[5];
    bit m_hold;
    bit m_err;
    bit h_vld;
    int h_item;
    bit h_rem;

    bill_cart_accumulator #(.QTY_W(4), .MAX_QTY(MAXQ)) dut (
        .clk(clk), .rst_n(rst_n), .scan_valid(scan_valid), .scan_item(scan_item),
        .scan_remove(scan_remove), .scan_ready(scan_ready), .checkout(checkout),
        .cart_ack(cart_ack), .undo(undo), .q1(q1), .q2(q2), .q3(q3), .q4(q4), .q5(q5),
        .item_total(item_total), .cart_valid(cart_valid), .cart_empty(cart_empty),
        .scan_err(scan_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // Cart rules expressed directly: a held flag, five integer counts, a one-entry history.
    task automatic model_step(input bit r, input bit v, input int it, input bit rm,
                              input bit co, input bit ak, input bit ud);
        m_err = 0;
        if (!r) begin
            foreach (m_q[i]) m_q[i] = 0;
            m_hold = 0;
            h_vld = 0;
        end else if (m_hold) begin
            if (ak) begin
                foreach (m_q[i]) m_q[i] = 0;
                m_hold = 0;
                h_vld = 0;
            end
        end else begin
            if (v) begin
                if (it > 4) m_err = 1;
                else if (rm && m_q[it] == 0) m_err = 1;
                else if (!rm && m_q[it] == MAXQ) m_err = 1;
                else begin
                    m_q[it] += rm ? -1 : 1;
                    h_vld = 1; h_item = it; h_rem = rm;
                end
            end
`ifdef CART_UNDO_EN
            else if (ud) begin
                if (h_vld) m_q[h_item] += h_rem ? 1 : -1;
                else m_err = 1;
                h_vld = 0;
            end
`endif
            if (co) begin
                m_hold = 1;
                h_vld = 0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        int sum;
        logic [3:0] qs[5];
        qs = '{q1, q2, q3, q4, q5};
        sum = 0;
        foreach (m_q[i]) begin
            sum += m_q[i];
            check($sformatf("%s_q%0d", tag, i + 1), 32'(qs[i]), m_q[i]);
        end
        check({tag, "_total"}, 32'(item_total), sum);
        check({tag, "_valid"}, 32'(cart_valid), 32'(m_hold));
        check({tag, "_empty"}, 32'(cart_empty), 32'(sum == 0));
        check({tag, "_err"}, 32'(scan_err), 32'(m_err));
        check({tag, "_ready"}, 32'(scan_ready), 32'(!m_hold));
    endtask

    task automatic cyc(input string tag, input bit r, input bit v, input int it, input bit rm,
                       input bit co, input bit ak, input bit ud);
        rst_n = r; scan_valid = v; scan_item = 3'(it); scan_remove = rm;
        checkout = co; cart_ack = ak; undo = ud;
        @(posedge clk);
        model_step(r, v, it, rm, co, ak, ud);
        #1;
        check_all(tag);
    endtask

    task automatic add(input int it);
        cyc("add", 1, 1, it, 0, 0, 0, 0);
    endtask

    initial begin
        int cnt[5];
        cyc("reset", 0, 0, 0, 0, 0, 0, 0);
        cyc("reset2", 0, 1, 1, 0, 1, 0, 0);
        check("reset_q1", 32'(q1), 0);
        check("reset_empty", 32'(cart_empty), 1);

        // Mixed cart, then checkout
        cnt = '{10, 2, 5, 10, 4};
        foreach (cnt[i]) for (int k = 0; k < cnt[i]; k++) add(i);
        cyc("checkout", 1, 0, 0, 0, 1, 0, 0);
        check("tp1_q1", 32'(q1), 10);
        check("tp1_q2", 32'(q2), 2);
        check("tp1_q3", 32'(q3), 5);
        check("tp1_q4", 32'(q4), 10);
        check("tp1_q5", 32'(q5), 4);
        check("tp1_total", 32'(item_total), 31);
        check("tp1_ready", 32'(scan_ready), 0);
        check("tp1_valid", 32'(cart_valid), 1);
        cyc("ack", 1, 0, 0, 0, 0, 1, 0);

        // Saturation and underflow
        for (int k = 0; k < 15; k++) add(2);
        check("sat_q3", 32'(q3), 15);
        add(2);
        check("sat_err", 32'(scan_err), 1);
        check("sat_q3b", 32'(q3), 15);
        cyc("rm_empty", 1, 1, 4, 1, 0, 0, 0);
        check("under_err", 32'(scan_err), 1);
        check("under_q5", 32'(q5), 0);
        cyc("illegal", 1, 1, 6, 0, 0, 0, 0);
        check("illegal_err", 32'(scan_err), 1);

        // HOLD ignores scans and checkout, then ack clears
        cyc("co2", 1, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 5; k++) cyc("hold", 1, 1, k, 0, 1, 0, 0);
        check("hold_q3", 32'(q3), 15);
        check("hold_err", 32'(scan_err), 0);
        cyc("ack2", 1, 0, 0, 0, 0, 1, 0);
        check("ack_valid", 32'(cart_valid), 0);
        check("ack_empty", 32'(cart_empty), 1);
        check("ack_q3", 32'(q3), 0);

        // Empty checkout, then same-cycle scan + checkout
        cyc("co_empty", 1, 0, 0, 0, 1, 1, 0);
        check("coe_valid", 32'(cart_valid), 1);
        check("coe_total", 32'(item_total), 0);
        cyc("ack3", 1, 0, 0, 0, 0, 1, 0);
        add(0);
        cyc("add_co", 1, 1, 0, 0, 1, 0, 0);
        check("addco_q1", 32'(q1), 2);
        check("addco_valid", 32'(cart_valid), 1);
        cyc("ack4", 1, 0, 0, 0, 0, 1, 0);

        // Full cart, reset in HOLD
        for (int i = 0; i < 5; i++) for (int k = 0; k < 15; k++) add(i);
        check("full_total", 32'(item_total), 75);
        cyc("co_full", 1, 0, 0, 0, 1, 0, 0);
        cyc("rst_hold", 0, 0, 0, 0, 0, 0, 0);
        check("rst_total", 32'(item_total), 0);
        check("rst_ready", 32'(scan_ready), 1);
        check("rst_valid", 32'(cart_valid), 0);

`ifdef CART_UNDO_EN
        add(1);
        cyc("undo", 1, 0, 0, 0, 0, 0, 1);
        check("undo_q2", 32'(q2), 0);
        check("undo_empty", 32'(cart_empty), 1);
        cyc("undo2", 1, 0, 0, 0, 0, 0, 1);
        check("undo2_err", 32'(scan_err), 1);
`else
        add(1);
        cyc("undo_off", 1, 0, 0, 0, 0, 0, 1);
        check("undo_off_q2", 32'(q2), 1);
`endif

        // Random traffic against the model
        for (int n = 0; n < 2000; n++) begin
            cyc("rnd",
                $urandom_range(63) != 0,
                $urandom_range(9) < 7,
                ($urandom_range(7) == 7) ? int'($urandom_range(7)) : int'($urandom_range(4)),
                $urandom_range(9) < 3,
                $urandom_range(29) == 0,
                $urandom_range(2) == 0,
                $urandom_range(5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
